vga_draw_scheduler: RTL and testbench

//  Sole owner of the vga_adapter plot port (x/y/colour/plot). Once per frame tick it:
//   - erases last frame's objects in black: left pad, right pad, ball;
//   - pulses move_strobe so the datapath advances the game;
//   - latches the new positions and redraws the objects in FG colour.

---
 rtl/pong_pkg.sv | 58 +++++
 rtl/vga_draw_scheduler_rect_sweeper.sv | 52 +++++
 rtl/vga_draw_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_vga_draw_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types for the pong frame scheduler: FSM states, object ids, colours.
// The DRAW_NET state only exists when DRAW_CENTER_LINE_EN is defined.
package pong_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ERASE_L,
        S_ERASE_R,
        S_ERASE_B,
        S_MOVE,
        S_LATCH,
`ifdef DRAW_CENTER_LINE_EN
        S_DRAW_NET,
`endif
        S_DRAW_L,
        S_DRAW_R,
        S_DRAW_B,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OBJ_LPAD,
        OBJ_RPAD,
        OBJ_BALL,
        OBJ_NET
    } obj_t;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    // States that walk a rectangle one pixel per cycle
    function automatic logic is_sweep(input state_t s);
        logic r;
        case (s)
            S_ERASE_L, S_ERASE_R, S_ERASE_B,
`ifdef DRAW_CENTER_LINE_EN
            S_DRAW_NET,
`endif
            S_DRAW_L, S_DRAW_R, S_DRAW_B: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

    // Which object's rectangle a sweep state is walking
    function automatic obj_t state_obj(input state_t s);
        obj_t r;
        case (s)
            S_ERASE_R, S_DRAW_R: r = OBJ_RPAD;
            S_ERASE_B, S_DRAW_B: r = OBJ_BALL;
`ifdef DRAW_CENTER_LINE_EN
            S_DRAW_NET:          r = OBJ_NET;
`endif
            default:             r = OBJ_LPAD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vga_draw_scheduler_rect_sweeper.sv
// rect_sweeper: raster walk of a w x h rectangle, x fastest, one pixel per
// cycle. Origin and size are live inputs; only the offsets are stored, so the
// parent can switch rectangles by pulsing start on the last pixel of the
// previous one. Coordinates are widened by one bit; clipping is the parent's.
module rect_sweeper (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [8:0] i_x0,
    input  logic [7:0] i_y0,
    input  logic [8:0] i_w,
    input  logic [7:0] i_h,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic       o_valid,
    output logic       o_last
);

    logic [8:0] r_ox;
    logic [7:0] r_oy;
    logic       r_act;
    logic       w_row_end;

    assign w_row_end = (r_ox == i_w - 9'd1);
    assign o_last    = r_act && w_row_end && (r_oy == i_h - 8'd1);
    assign o_valid   = r_act;
    assign o_x       = {1'b0, i_x0} + {1'b0, r_ox};
    assign o_y       = {1'b0, i_y0} + {1'b0, r_oy};

    // Offset counters: restart on start, otherwise advance until the last pixel
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_act <= 1'b0;
            r_ox  <= '0;
            r_oy  <= '0;
        end else if (i_start) begin
            r_act <= 1'b1;
            r_ox  <= '0;
            r_oy  <= '0;
        end else if (r_act) begin
            if (o_last) begin
                r_act <= 1'b0;
            end else if (w_row_end) begin
                r_ox <= '0;
                r_oy <= r_oy + 8'd1;
            end else begin
                r_ox <= r_ox + 9'd1;
            end
        end
    end

endmodule

// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler: owns the vga_adapter plot port. On each frame tick it
// erases last frame's paddles and ball, strobes the datapath to move, latches
// the new positions and redraws them. Define DRAW_CENTER_LINE_EN to add a
// dashed centre net drawn after the latch (never erased).
module vga_draw_scheduler
    import pong_pkg::*;
#(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         FRAME_HZ = 60,
    parameter int         SCR_W    = 160,
    parameter int         SCR_H    = 120,
    parameter int         PAD_XL   = 4,
    parameter int         PAD_XR   = 154,
    parameter int         PAD_W    = 2,
    parameter int         PAD_H    = 16,
    parameter int         BALL_SZ  = 2,
    parameter logic [2:0] FG       = 3'b111
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [7:0] i_left_pad_y,
    input  logic [7:0] i_right_pad_y,
    input  logic [8:0] i_ball_x,
    input  logic [7:0] i_ball_y,
    output logic       o_move_strobe,
    output logic [8:0] o_x,
    output logic [7:0] o_y,
    output logic [2:0] o_colour,
    output logic       o_plot,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_overrun
);

    localparam int TICK_N = CLK_HZ / FRAME_HZ;
    localparam int CNT_W  = (TICK_N > 1) ? $clog2(TICK_N) : 1;

    state_t           r_state;
    logic             r_first;
    logic [7:0]       r_prev_l, r_prev_r, r_prev_by;
    logic [8:0]       r_prev_bx;
    logic             r_ovr;
    logic [CNT_W-1:0] r_cnt;
    logic [8:0]       r_x;
    logic [7:0]       r_y;
    logic [2:0]       r_col;

    logic             w_tick;
    logic             w_start, w_last, w_valid;
    logic [8:0]       w_x0, w_w;
    logic [7:0]       w_y0, w_h;
    logic [9:0]       w_sx;
    logic [8:0]       w_sy;
    logic             w_in_scr, w_dash, w_plot, w_erasing;
    logic [2:0]       w_colour;

    assign w_tick = (r_cnt == CNT_W'(TICK_N - 1));

    // Free-running frame tick divider
    always_ff @(posedge i_clk) begin
        if (i_reset || w_tick) r_cnt <= '0;
        else                   r_cnt <= r_cnt + 1'b1;
    end

    // Rectangle geometry for the object the current state is sweeping
    always_comb begin
        w_x0 = 9'(PAD_XL);
        w_y0 = r_prev_l;
        w_w  = 9'(PAD_W);
        w_h  = 8'(PAD_H);
        case (state_obj(r_state))
            OBJ_RPAD: begin
                w_x0 = 9'(PAD_XR);
                w_y0 = r_prev_r;
            end
            OBJ_BALL: begin
                w_x0 = r_prev_bx;
                w_y0 = r_prev_by;
                w_w  = 9'(BALL_SZ);
                w_h  = 8'(BALL_SZ);
            end
            OBJ_NET: begin
                w_x0 = 9'(SCR_W / 2);
                w_y0 = 8'd0;
                w_w  = 9'd1;
                w_h  = 8'(SCR_H);
            end
            default: ;
        endcase
    end

    // Restart the sweeper whenever the FSM is about to enter a sweep state
    always_comb begin
        w_start = 1'b0;
        case (r_state)
            S_IDLE:               w_start = w_tick && i_enable && !r_first;
            S_ERASE_L, S_ERASE_R: w_start = w_last;
            S_LATCH:              w_start = 1'b1;
`ifdef DRAW_CENTER_LINE_EN
            S_DRAW_NET:           w_start = w_last;
`endif
            S_DRAW_L, S_DRAW_R:   w_start = w_last;
            default:              w_start = 1'b0;
        endcase
    end

    rect_sweeper u_sweep (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_start),
        .i_x0    (w_x0),
        .i_y0    (w_y0),
        .i_w     (w_w),
        .i_h     (w_h),
        .o_x     (w_sx),
        .o_y     (w_sy),
        .o_valid (w_valid),
        .o_last  (w_last)
    );

    // Off-screen pixels burn their cycle with plot low
    assign w_in_scr = (w_sx < 10'(SCR_W)) && (w_sy < 9'(SCR_H));
`ifdef DRAW_CENTER_LINE_EN
    assign w_dash = (r_state != S_DRAW_NET) || !w_sy[2];
`else
    assign w_dash = 1'b1;
`endif
    assign w_erasing = (r_state == S_ERASE_L) || (r_state == S_ERASE_R) ||
                       (r_state == S_ERASE_B);
    assign w_colour  = w_erasing ? COLOUR_BLACK : FG;
    assign w_plot    = is_sweep(r_state) && w_valid && w_in_scr && w_dash;

    // Frame sequencer: erase, move, latch, draw, done
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_first   <= 1'b1;
            r_prev_l  <= '0;
            r_prev_r  <= '0;
            r_prev_bx <= '0;
            r_prev_by <= '0;
            r_ovr     <= 1'b0;
        end else begin
            r_ovr <= w_tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE:    if (w_tick && i_enable) r_state <= r_first ? S_MOVE : S_ERASE_L;
                S_ERASE_L: if (w_last) r_state <= S_ERASE_R;
                S_ERASE_R: if (w_last) r_state <= S_ERASE_B;
                S_ERASE_B: if (w_last) r_state <= S_MOVE;
                S_MOVE:    r_state <= S_LATCH;
                S_LATCH: begin
                    r_prev_l  <= i_left_pad_y;
                    r_prev_r  <= i_right_pad_y;
                    r_prev_bx <= i_ball_x;
                    r_prev_by <= i_ball_y;
                    r_first   <= 1'b0;
`ifdef DRAW_CENTER_LINE_EN
                    r_state   <= S_DRAW_NET;
`else
                    r_state   <= S_DRAW_L;
`endif
                end
`ifdef DRAW_CENTER_LINE_EN
                S_DRAW_NET: if (w_last) r_state <= S_DRAW_L;
`endif
                S_DRAW_L:  if (w_last) r_state <= S_DRAW_R;
                S_DRAW_R:  if (w_last) r_state <= S_DRAW_B;
                S_DRAW_B:  if (w_last) r_state <= S_DONE;
                S_DONE:    r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Remember the last plotted pixel so x/y/colour hold while plot is low
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x   <= '0;
            r_y   <= '0;
            r_col <= '0;
        end else if (w_plot) begin
            r_x   <= w_sx[8:0];
            r_y   <= w_sy[7:0];
            r_col <= w_colour;
        end
    end

    assign o_plot        = w_plot;
    assign o_x           = w_plot ? w_sx[8:0] : r_x;
    assign o_y           = w_plot ? w_sy[7:0] : r_y;
    assign o_colour      = w_plot ? w_colour  : r_col;
    assign o_move_strobe = (r_state == S_MOVE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = (r_state == S_DONE);
    assign o_overrun     = r_ovr;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Bench for vga_draw_scheduler. DUT a ticks every 100 cycles and is checked
// pixel by pixel against a frame-list model; DUT b ticks every cycle so
// every frame overruns, and is checked for frame length and overrun pulses.
module tb_vga_draw_scheduler;

    localparam int N_A = 100;
`ifdef DRAW_CENTER_LINE_EN
    localparam int NET_CYC = 120;
`else
    localparam int NET_CYC = 0;
`endif
    localparam int FG = 7;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, en_a;
    logic [7:0] lpy, rpy, by;
    logic [8:0] bx;

    logic       a_move, a_plot, a_busy, a_done, a_ovr;
    logic [8:0] a_x;
    logic [7:0] a_y;
    logic [2:0] a_col;
    logic       b_move, b_plot, b_busy, b_done, b_ovr;
    logic [8:0] b_x;
    logic [7:0] b_y;
    logic [2:0] b_col;

    vga_draw_scheduler #(.CLK_HZ(1000), .FRAME_HZ(10)) u_a (
        .i_clk(clk), .i_reset(rst_a), .i_enable(en_a),
        .i_left_pad_y(lpy), .i_right_pad_y(rpy), .i_ball_x(bx), .i_ball_y(by),
        .o_move_strobe(a_move), .o_x(a_x), .o_y(a_y), .o_colour(a_col),
        .o_plot(a_plot), .o_busy(a_busy), .o_frame_done(a_done), .o_overrun(a_ovr)
    );

    vga_draw_scheduler #(.CLK_HZ(1000), .FRAME_HZ(1000)) u_b (
        .i_clk(clk), .i_reset(rst_b), .i_enable(1'b1),
        .i_left_pad_y(lpy), .i_right_pad_y(rpy), .i_ball_x(bx), .i_ball_y(by),
        .o_move_strobe(b_move), .o_x(b_x), .o_y(b_y), .o_colour(b_col),
        .o_plot(b_plot), .o_busy(b_busy), .o_frame_done(b_done), .o_overrun(b_ovr)
    );

    typedef struct {
        bit plot;
        int x;
        int y;
        int col;
        bit strobe;
        bit done;
        int tag;   // 0 erase, 1 move, 2 latch, 3 net, 4 lpad, 5 rpad, 6 ball, 7 done
    } rec_t;

    typedef struct {
        int l;
        int r;
        int bx;
        int by;
    } pos_t;

    rec_t q[$];
    pos_t plan[32];
    pos_t prv;
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    int   cnt, k, p, hx, hy, hc;
    bit   first, m_ovr;
    int   b_rem;
    bit   b_first, b_ovr_m;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, act, exp);
        end
    endtask

    task automatic push(input bit pl, input int x, input int y, input int col,
                        input bit st, input bit dn, input int tag);
        rec_t r;
        r.plot = pl; r.x = x; r.y = y; r.col = col;
        r.strobe = st; r.done = dn; r.tag = tag;
        q.push_back(r);
    endtask

    // One record per cycle of the sweep; clipped pixels still take their cycle
    task automatic push_rect(input int x0, input int y0, input int w, input int h,
                             input int col, input int tag);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                push((x0 + xx < 160) && (y0 + yy < 120), x0 + xx, y0 + yy, col, 0, 0, tag);
    endtask

    // Whole-frame expectation, built the moment the frame starts
    task automatic build_frame();
        pos_t nw;
        nw = plan[k];
        if (!first) begin
            push_rect(4,   prv.l,  2, 16, 0, 0);
            push_rect(154, prv.r,  2, 16, 0, 0);
            push_rect(prv.bx, prv.by, 2, 2, 0, 0);
        end
        push(0, 0, 0, 0, 1, 0, 1);
        push(0, 0, 0, 0, 0, 0, 2);
`ifdef DRAW_CENTER_LINE_EN
        for (int yy = 0; yy < 120; yy++) push((yy % 8) < 4, 80, yy, FG, 0, 0, 3);
`endif
        push_rect(4,   nw.l,  2, 16, FG, 4);
        push_rect(154, nw.r,  2, 16, FG, 5);
        push_rect(nw.bx, nw.by, 2, 2, FG, 6);
        push(0, 0, 0, 0, 0, 1, 7);
        prv   = nw;
        first = 0;
        k++;
    endtask

    initial begin
        rec_t cur;
        bit   busy, tick, did_rst, en_off;
        rst_a = 1; rst_b = 1; en_a = 1;
        lpy = 0; rpy = 0; bx = 0; by = 0;
        plan[0] = '{10, 50, 40, 30};
        plan[1] = '{10, 50, 42, 30};
        plan[2] = '{10, 110, 159, 60};
        for (int i = 3; i < 32; i++)
            plan[i] = '{int'($urandom_range(0, 125)), int'($urandom_range(0, 125)),
                        int'($urandom_range(0, 165)), int'($urandom_range(0, 125))};
        cnt = 0; k = 0; p = 0; hx = 0; hy = 0; hc = 0; first = 1; m_ovr = 0;
        prv = '{0, 0, 0, 0};
        b_rem = 0; b_first = 1; b_ovr_m = 0;
        did_rst = 0; en_off = 0;
        cur = '{0, 0, 0, 0, 0, 0, -1};

        for (int c = 0; c < 2200; c++) begin
            @(negedge clk);
            cyc = c;
            // ---- compare this cycle
            if (q.size() != 0) cur = q[0];
            else               cur = '{0, 0, 0, 0, 0, 0, -1};
            if (cur.plot) begin hx = cur.x; hy = cur.y; hc = cur.col; end
            chk("plot",    a_plot, cur.plot);
            chk("x",       a_x,    hx);
            chk("y",       a_y,    hy);
            chk("colour",  a_col,  hc);
            chk("strobe",  a_move, cur.strobe);
            chk("busy",    a_busy, q.size() != 0);
            chk("done",    a_done, cur.done);
            chk("overrun", a_ovr,  m_ovr);
            chk("b_busy",  b_busy, b_rem > 0);
            chk("b_done",  b_done, b_rem == 1);
            chk("b_ovr",   b_ovr,  b_ovr_m);

            // ---- datapath: new positions in response to the move strobe
            if (a_move && p < 32) begin
                lpy = 8'(plan[p].l); rpy = 8'(plan[p].r);
                bx  = 9'(plan[p].bx); by = 8'(plan[p].by);
                p++;
            end

            // ---- scenario: power-on reset, mid-draw reset, enable drop
            rst_a = (c < 3);
            rst_b = (c < 3);
            if (c >= 600 && !did_rst && q.size() != 0 && q[0].tag == 4) begin
                rst_a   = 1;
                did_rst = 1;
            end
            if (c >= 1100 && c < 1400 && q.size() > 20) en_off = 1;
            if (c >= 1400) en_off = 0;
            en_a = !en_off;

            // ---- advance reference model across the coming edge
            if (rst_a) begin
                q.delete();
                cnt = 0; first = 1; prv = '{0, 0, 0, 0};
                hx = 0; hy = 0; hc = 0; m_ovr = 0;
            end else begin
                busy  = (q.size() != 0);
                tick  = (cnt == N_A - 1);
                m_ovr = tick && busy;
                if (busy) void'(q.pop_front());
                if (tick && !busy && en_a) build_frame();
                cnt = (cnt + 1) % N_A;
            end

            if (rst_b) begin
                b_rem = 0; b_first = 1; b_ovr_m = 0;
            end else begin
                b_ovr_m = (b_rem > 0);
                if (b_rem > 0) b_rem--;
                else begin
                    b_rem   = (b_first ? 71 : 139) + NET_CYC;
                    b_first = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
